// File: rtl/sprite_pkg.sv
// Shared defaults, slot-entry payload and scheduler state encoding for the sprite line scheduler.
package sprite_pkg;

  localparam int unsigned COORD_W          = 10;
  localparam int unsigned DEF_NUM_SLOTS    = 16;
  localparam int unsigned DEF_LINE_SPRITES = 4;
  localparam int unsigned DEF_SPRITE_SIZE  = 8;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               en;
  } slot_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EVAL   = 2'd1,
    ST_DONE   = 2'd2,
    ST_COMMIT = 2'd3
  } sched_state_t;

endpackage

// File: rtl/sprite_prio_mux.sv
// Registered priority merge of per-renderer pixels: the lowest line index with a valid pixel wins.
module sprite_prio_mux #(
  parameter int unsigned LINE_SPRITES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [LINE_SPRITES-1:0]   pix_valid,
  input  logic [LINE_SPRITES*3-1:0] pix_rgb,
  output logic [2:0]                out_rgb,
  output logic                      out_valid
);

  logic [2:0] sel_rgb;
  logic       sel_valid;

  // Walk from the highest index down so the lowest valid index is applied last.
  always_comb begin
    sel_rgb   = 3'd0;
    sel_valid = 1'b0;
    for (int i = int'(LINE_SPRITES) - 1; i >= 0; i--) begin
      if (pix_valid[i]) begin
        sel_rgb   = pix_rgb[i*3 +: 3];
        sel_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_rgb   <= 3'd0;
      out_valid <= 1'b0;
    end else begin
      out_rgb   <= sel_rgb;
      out_valid <= sel_valid;
    end
  end

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: double-buffered slot table, one-slot-per-cycle hit scan, priority merge.
// Optional SPRITE_OVF_CNT_EN adds ovf_cnt, a saturating count of overflowed scanlines.
module sprite_line_scheduler
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SLOTS    = DEF_NUM_SLOTS,
  parameter int unsigned LINE_SPRITES = DEF_LINE_SPRITES,
  parameter int unsigned SPRITE_SIZE  = DEF_SPRITE_SIZE
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 frame_start,
  input  logic                                 hblank_start,
  input  logic [COORD_W-1:0]                   next_y,
  input  logic                                 wr_valid,
  output logic                                 wr_ready,
  input  logic [$clog2(NUM_SLOTS)-1:0]         wr_slot,
  input  logic [COORD_W-1:0]                   wr_x,
  input  logic [COORD_W-1:0]                   wr_y,
  input  logic                                 wr_en,
  output logic [LINE_SPRITES*COORD_W-1:0]      line_x,
  output logic [LINE_SPRITES*COORD_W-1:0]      line_y,
  output logic [LINE_SPRITES-1:0]              line_act,
  input  logic [LINE_SPRITES-1:0]              pix_valid,
  input  logic [LINE_SPRITES*3-1:0]            pix_rgb,
  output logic [2:0]                           out_rgb,
  output logic                                 out_valid,
  output logic                                 busy,
`ifdef SPRITE_OVF_CNT_EN
  output logic [7:0]                           ovf_cnt,
`endif
  output logic                                 overflow
);

  localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
  localparam int unsigned CNT_W  = $clog2(LINE_SPRITES + 1);

  sched_state_t state, state_nxt;

  slot_entry_t shadow_tbl [NUM_SLOTS];
  slot_entry_t active_tbl [NUM_SLOTS];

  logic [SLOT_W-1:0]                slot_idx;
  logic [COORD_W-1:0]               y_lat;
  logic [CNT_W-1:0]                 pend_cnt;
  logic [LINE_SPRITES*COORD_W-1:0]  pend_x;
  logic [LINE_SPRITES*COORD_W-1:0]  pend_y;
  logic                             commit_pend;
  logic                             line_ovf;

  slot_entry_t                      cur;
  logic [COORD_W-1:0]               dy;
  logic                             hit;
  logic [LINE_SPRITES-1:0]          act_mask;

  // Hit test: unsigned wrap makes sprites below the scanline miss.
  always_comb begin
    cur = active_tbl[slot_idx];
    dy  = y_lat - cur.y;
    hit = (state == ST_EVAL) && cur.en && (dy < COORD_W'(SPRITE_SIZE));
  end

  always_comb begin
    act_mask = '0;
    for (int i = 0; i < int'(LINE_SPRITES); i++) begin
      act_mask[i] = (CNT_W'(i) < pend_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (frame_start)       state_nxt = ST_COMMIT;
        else if (hblank_start) state_nxt = ST_EVAL;
      end
      ST_EVAL: begin
        if (slot_idx == SLOT_W'(NUM_SLOTS - 1)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (commit_pend || frame_start) state_nxt = ST_COMMIT;
        else                            state_nxt = ST_IDLE;
      end
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Tables, pending list and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        shadow_tbl[i] <= '0;
        active_tbl[i] <= '0;
      end
      slot_idx    <= '0;
      y_lat       <= '0;
      pend_cnt    <= '0;
      pend_x      <= '0;
      pend_y      <= '0;
      commit_pend <= 1'b0;
      line_ovf    <= 1'b0;
      line_x      <= '0;
      line_y      <= '0;
      line_act    <= '0;
      busy        <= 1'b0;
      wr_ready    <= 1'b1;
      overflow    <= 1'b0;
`ifdef SPRITE_OVF_CNT_EN
      ovf_cnt     <= 8'd0;
`endif
    end else begin
      busy     <= (state_nxt == ST_EVAL) || (state_nxt == ST_DONE);
      wr_ready <= (state_nxt != ST_COMMIT);

      if (wr_valid && wr_ready) begin
        shadow_tbl[wr_slot] <= '{x: wr_x, y: wr_y, en: wr_en};
      end

      case (state)
        ST_IDLE: begin
          if (state_nxt == ST_EVAL) begin
            y_lat    <= next_y;
            slot_idx <= '0;
            pend_cnt <= '0;
            pend_x   <= '0;
            pend_y   <= '0;
            line_ovf <= 1'b0;
          end
        end
        ST_EVAL: begin
          slot_idx <= slot_idx + SLOT_W'(1);
          if (frame_start) commit_pend <= 1'b1;
          if (hit) begin
            if (pend_cnt < CNT_W'(LINE_SPRITES)) begin
              pend_x[int'(pend_cnt)*COORD_W +: COORD_W] <= cur.x;
              pend_y[int'(pend_cnt)*COORD_W +: COORD_W] <= cur.y;
              pend_cnt <= pend_cnt + CNT_W'(1);
            end else begin
              overflow <= 1'b1;
              line_ovf <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          line_x      <= pend_x;
          line_y      <= pend_y;
          line_act    <= act_mask;
          commit_pend <= 1'b0;
`ifdef SPRITE_OVF_CNT_EN
          if (line_ovf && (ovf_cnt != 8'd255)) ovf_cnt <= ovf_cnt + 8'd1;
`endif
        end
        ST_COMMIT: begin
          for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            active_tbl[i] <= shadow_tbl[i];
          end
          overflow <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  sprite_prio_mux #(
    .LINE_SPRITES(LINE_SPRITES)
  ) u_prio_mux (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_valid (pix_valid),
    .pix_rgb   (pix_rgb),
    .out_rgb   (out_rgb),
    .out_valid (out_valid)
  );

endmodule
